// File: rtl/display_pkg.sv
// Shared types for the display datapath: geometry, pixel address/colour
// types and the rectangle-fill state encoding.
package display_pkg;

  localparam int XW = 7;
  localparam int YW = 6;
  localparam int CW = 24;

  typedef logic [XW+YW-1:0] pix_addr_t;
  typedef logic [CW-1:0]    rgb_t;

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  function automatic pix_addr_t pack_addr(
    input logic [YW-1:0] y,
    input logic [XW-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/display_raster_ctr.sv
// Raster x/y scan counter: loads a start corner, steps in raster order
// inside the latched column span, flags the bottom-right pixel.
module display_raster_ctr
  import display_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [XW-1:0] ld_x_i,
  input  logic [YW-1:0] ld_y_i,
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] x1_i,
  input  logic [YW-1:0] y1_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = ld_x_i;
      y_d = ld_y_i;
    end else if (step_i) begin
      if (x_q == x1_i) begin
        x_d = x0_i;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == x1_i) && (y_q == y1_i);

endmodule

// File: rtl/display_rect_fill.sv
// Rectangle-fill engine: takes one fill command, streams one pixel write
// per clock in raster order into the display memory port.
module display_rect_fill
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [XW-1:0]    cmd_x0,
  input  logic [YW-1:0]    cmd_y0,
  input  logic [XW-1:0]    cmd_x1,
  input  logic [YW-1:0]    cmd_y1,
  input  logic [CW-1:0]    cmd_color,
  output logic [XW+YW-1:0] mem_waddr,
  output logic [CW-1:0]    mem_wdata,
  output logic             mem_web,
  output logic             busy,
  output logic             done
);

  state_e        state_q, state_d;
  logic [XW-1:0] x0_q, x0_d;
  logic [XW-1:0] x1_q, x1_d;
  logic [YW-1:0] y1_q, y1_d;
  rgb_t          wdata_q, wdata_d;
  logic          web_q, web_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load, step, last;
  logic [XW-1:0] x_cur;
  logic [YW-1:0] y_cur;

  display_raster_ctr u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (step),
    .ld_x_i (cmd_x0),
    .ld_y_i (cmd_y0),
    .x0_i   (x0_q),
    .x1_i   (x1_q),
    .y1_i   (y1_q),
    .x_o    (x_cur),
    .y_o    (y_cur),
    .last_o (last)
  );

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    wdata_d = wdata_q;
    web_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d = cmd_x0;
          x1_d = cmd_x1;
          y1_d = cmd_y1;
          // An inverted corner pair is an empty fill: complete at once.
          if (cmd_x0 > cmd_x1 || cmd_y0 > cmd_y1) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            busy_d  = 1'b1;
            web_d   = 1'b1;
            load    = 1'b1;
            wdata_d = cmd_color;
          end
        end
      end
      FILL: begin
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          step   = 1'b1;
          busy_d = 1'b1;
          web_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      wdata_q <= '0;
      web_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      wdata_q <= wdata_d;
      web_q   <= web_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign mem_waddr = pack_addr(y_cur, x_cur);
  assign mem_wdata = wdata_q;
  assign mem_web   = web_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_display_rect_fill.sv
// Bench for display_rect_fill: raster-order reference model, write and
// done-pulse timing, back-to-back and reset-abort scenarios.
module tb_display_rect_fill;
  import display_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [6:0]    cmd_x0 = '0;
  logic [5:0]    cmd_y0 = '0;
  logic [6:0]    cmd_x1 = '0;
  logic [5:0]    cmd_y1 = '0;
  logic [23:0]   cmd_color = '0;
  logic [12:0]   mem_waddr;
  logic [23:0]   mem_wdata;
  logic          mem_web;
  logic          busy;
  logic          done;

  display_rect_fill dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_web   (mem_web),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [12:0] a;
    logic [23:0] d;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_cnt = 0;
  wr_t         wq[$];
  int          dq[$];
  logic [12:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (rst_n) begin
      if (mem_web) begin
        w.c = cyc;
        w.a = mem_waddr;
        w.d = mem_wdata;
        wq.push_back(w);
      end
      if (done) dq.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    dq.delete();
    busy_cnt = 0;
  endtask

  // Reference: every (x,y) inside the inclusive box, rows top to bottom.
  task automatic build_exp(input int x0, input int y0,
                           input int x1, input int y1);
    exp_q.delete();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        exp_q.push_back(13'(y * 128 + x));
  endtask

  task automatic send(input int x0, input int y0, input int x1,
                      input int y1, input logic [23:0] col,
                      output int acc);
    acc = -1;
    tick();
    cmd_valid = 1'b1;
    cmd_x0 = 7'(x0);
    cmd_y0 = 6'(y0);
    cmd_x1 = 7'(x1);
    cmd_y1 = 6'(y1);
    cmd_color = col;
    for (int i = 0; i < 20000; i++) begin
      if (cmd_ready) begin
        acc = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 7'($urandom);
        cmd_y0 = 6'($urandom);
        cmd_x1 = 7'($urandom);
        cmd_y1 = 6'($urandom);
        cmd_color = 24'($urandom);
        break;
      end
      tick();
    end
    checks++;
    if (acc < 0) begin
      errors++;
      cmd_valid = 1'b0;
      $display("FAIL send_timeout got no accept exp accept");
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && dq.size() == 0; i++) tick();
    tick();
    checks++;
    if (dq.size() == 0) begin
      errors++;
      $display("FAIL done_timeout got no done exp done pulse");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({mem_web, busy, done} !== 3'b000 || mem_waddr !== 13'h0
        || mem_wdata !== 24'h0) begin
      errors++;
      $display("FAIL reset_outs got web=%b busy=%b done=%b a=%h d=%h exp 0",
               mem_web, busy, done, mem_waddr, mem_wdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || mem_web !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got rdy=%b web=%b exp rdy=1 web=0",
               cmd_ready, mem_web);
    end
  endtask

  task automatic test_single();
    int acc;
    int n;
    clear_log();
    send(5, 3, 5, 3, 24'hFF0000, acc);
    wait_done(50);
    build_exp(5, 3, 5, 3);
    n = exp_q.size();
    checks++;
    if (wq.size() != 1 || wq[0].a !== 13'h0185 || wq[0].d !== 24'hFF0000
        || wq[0].c != acc + 1) begin
      errors++;
      $display("FAIL single_wr got n=%0d exp n=1 a=0185 d=FF0000",
               wq.size());
    end
    checks++;
    if (dq.size() != 1 || dq[0] != acc + n + 1) begin
      errors++;
      $display("FAIL single_done got n=%0d exp one pulse at %0d",
               dq.size(), acc + n + 1);
    end
  endtask

  task automatic test_rect();
    int acc;
    int n;
    clear_log();
    send(10, 1, 12, 2, 24'h00FF00, acc);
    wait_done(50);
    build_exp(10, 1, 12, 2);
    n = exp_q.size();
    checks++;
    if (wq.size() != n || n != 6) begin
      errors++;
      $display("FAIL rect_count got %0d exp 6", wq.size());
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wq[i].a !== exp_q[i] || wq[i].d !== 24'h00FF00
            || wq[i].c != acc + 1 + i) begin
          errors++;
          $display("FAIL rect_wr%0d got a=%h c=%0d exp a=%h c=%0d",
                   i, wq[i].a, wq[i].c, exp_q[i], acc + 1 + i);
        end
      end
    end
    checks++;
    if (dq.size() != 1 || dq[0] != acc + n + 1) begin
      errors++;
      $display("FAIL rect_done got n=%0d exp one pulse at %0d",
               dq.size(), acc + n + 1);
    end
  endtask

  task automatic test_empty();
    int acc;
    clear_log();
    send(20, 5, 19, 5, 24'h123456, acc);
    wait_done(20);
    tick();
    tick();
    checks++;
    if (wq.size() != 0 || busy_cnt != 0) begin
      errors++;
      $display("FAIL empty_nowr got wr=%0d busy=%0d exp 0 0",
               wq.size(), busy_cnt);
    end
    checks++;
    if (dq.size() != 1 || dq[0] != acc + 1) begin
      errors++;
      $display("FAIL empty_done got n=%0d exp one pulse at %0d",
               dq.size(), acc + 1);
    end
  endtask

  task automatic test_random();
    int acc;
    int n;
    int x0, y0, x1, y1;
    logic [23:0] col;
    for (int t = 0; t < 12; t++) begin
      clear_log();
      x0 = $urandom_range(0, 127);
      y0 = $urandom_range(0, 63);
      x1 = x0 + int'($urandom_range(0, 12)) - 2;
      y1 = y0 + int'($urandom_range(0, 6)) - 1;
      if (x1 > 127) x1 = 127;
      if (x1 < 0) x1 = 0;
      if (y1 > 63) y1 = 63;
      if (y1 < 0) y1 = 0;
      col = 24'($urandom);
      send(x0, y0, x1, y1, col, acc);
      wait_done(200);
      build_exp(x0, y0, x1, y1);
      n = exp_q.size();
      checks++;
      if (wq.size() != n) begin
        errors++;
        $display("FAIL rand%0d_count got %0d exp %0d", t, wq.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (wq[i].a !== exp_q[i] || wq[i].d !== col
              || wq[i].c != acc + 1 + i) begin
            errors++;
            $display("FAIL rand%0d_wr%0d got a=%h d=%h exp a=%h d=%h",
                     t, i, wq[i].a, wq[i].d, exp_q[i], col);
          end
        end
      end
      checks++;
      if (dq.size() != 1 || dq[0] != acc + n + 1) begin
        errors++;
        $display("FAIL rand%0d_done got n=%0d exp one pulse at %0d",
                 t, dq.size(), acc + n + 1);
      end
    end
  endtask

  task automatic test_full_screen();
    int acc;
    int bad;
    int n;
    clear_log();
    bad = 0;
    send(0, 0, 127, 63, 24'hA5C3E1, acc);
    cmd_valid = 1'b1;
    for (int i = 0; i < 9000 && dq.size() == 0; i++) begin
      tick();
      if (cmd_ready && dq.size() == 0) bad++;
      if (wq.size() >= 4000) cmd_valid = 1'b0;
      else begin
        cmd_x0 = 7'($urandom);
        cmd_x1 = 7'($urandom);
        cmd_color = 24'($urandom);
      end
    end
    cmd_valid = 1'b0;
    tick();
    build_exp(0, 0, 127, 63);
    n = exp_q.size();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_ready got %0d ready cycles exp 0", bad);
    end
    checks++;
    if (wq.size() != 8192 || wq[wq.size()-1].a !== 13'h1FFF) begin
      errors++;
      $display("FAIL full_count got %0d exp 8192 ending 1FFF", wq.size());
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (wq[i].a !== exp_q[i] || wq[i].d !== 24'hA5C3E1
            || wq[i].c != acc + 1 + i) begin
          errors++;
          $display("FAIL full_wr%0d got a=%h d=%h exp a=%h d=A5C3E1",
                   i, wq[i].a, wq[i].d, exp_q[i]);
        end
      end
    end
    checks++;
    if (dq.size() != 1 || dq[0] != acc + n + 1) begin
      errors++;
      $display("FAIL full_done got n=%0d exp one pulse at %0d",
               dq.size(), acc + n + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2;
    int n1, n2;
    logic [12:0] e1[$];
    clear_log();
    send(3, 7, 6, 9, 24'h0000FF, acc1);
    send(100, 60, 101, 61, 24'hFFFF00, acc2);
    wait_done(100);
    for (int i = 0; i < 40 && dq.size() < 2; i++) tick();
    build_exp(3, 7, 6, 9);
    e1 = exp_q;
    n1 = e1.size();
    build_exp(100, 60, 101, 61);
    n2 = exp_q.size();
    checks++;
    if (acc2 != acc1 + n1 + 1) begin
      errors++;
      $display("FAIL b2b_accept got %0d exp %0d", acc2, acc1 + n1 + 1);
    end
    checks++;
    if (wq.size() != n1 + n2) begin
      errors++;
      $display("FAIL b2b_count got %0d exp %0d", wq.size(), n1 + n2);
    end else begin
      checks++;
      if (wq[n1].c - wq[n1-1].c != 2) begin
        errors++;
        $display("FAIL b2b_gap got %0d exp 2", wq[n1].c - wq[n1-1].c);
      end
      for (int i = 0; i < n1 + n2; i++) begin
        checks++;
        if ((i < n1 && (wq[i].a !== e1[i] || wq[i].d !== 24'h0000FF))
            || (i >= n1 && (wq[i].a !== exp_q[i-n1]
                            || wq[i].d !== 24'hFFFF00))) begin
          errors++;
          $display("FAIL b2b_wr%0d got a=%h d=%h", i, wq[i].a, wq[i].d);
        end
      end
    end
    checks++;
    if (dq.size() != 2 || dq[0] != acc1 + n1 + 1
        || dq[1] != acc2 + n2 + 1) begin
      errors++;
      $display("FAIL b2b_done got n=%0d exp 2 pulses", dq.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    int acc;
    clear_log();
    send(0, 0, 127, 63, 24'h55AA55, acc);
    for (int i = 0; i < 300 && wq.size() < 100; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_web !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got web=%b busy=%b done=%b exp 0 0 0",
               mem_web, busy, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (wq.size() != 100 || dq.size() != 0) begin
      errors++;
      $display("FAIL abort_writes got wr=%0d done=%0d exp 100 0",
               wq.size(), dq.size());
    end
    checks++;
    if (cmd_ready !== 1'b1 || mem_web !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got rdy=%b web=%b exp 1 0",
               cmd_ready, mem_web);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rect();
    test_empty();
    test_random();
    test_full_screen();
    test_back_to_back();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
